exec_timer: RTL and testbench

Execution-time counter feeding the seven-segment display path. It watches the system state code, counts clock cycles spent in `process_exicute`, and scales them by a prescaler into a saturating 26-bit `timeValue`. When the system reaches `finish`, it freezes the value and issues a one-cycle `start_timeValue_convetion` pulse. That pulse starts the binary-to-BCD conversion whose digits the display shows in the `finish` state.

---
 rtl/exec_timer.sv | 85 ++++++++
 tb/tb_exec_timer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/exec_timer.sv
// Execution-time counter: counts prescaled cycles spent in process_exicute into a
// saturating timeValue, and pulses start_timeValue_convetion on entry to finish.
module exec_timer #(
  parameter int PRESCALE = 1,
  parameter int WIDTH    = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       state,
  output logic [WIDTH-1:0] timeValue,
  output logic             start_timeValue_convetion,
  output logic             running,
  output logic             overflow
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PMAX = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] TMAX = '1;
  localparam logic [2:0] ST_EXEC = 3'd4;
  localparam logic [2:0] ST_FIN  = 3'd6;

  typedef enum logic [1:0] {IDLE, COUNT, HELD} fsm_t;

  fsm_t             r_fsm;
  logic [2:0]       r_prev_state;
  logic [PW-1:0]    r_presc;

  logic             w_entry;
  logic             w_fin;
  logic             w_count;
  logic [PW-1:0]    w_presc_cur;
  logic [WIDTH-1:0] w_tv_cur;
  logic             w_ovf_cur;
  logic             w_wrap;

  assign w_entry = (state == ST_EXEC) && (r_prev_state != ST_EXEC);
  assign w_fin   = (state == ST_FIN)  && (r_prev_state != ST_FIN);
  assign w_count = w_entry || ((r_fsm == COUNT) && (state == ST_EXEC));

  // Entry clears the measurement and counts its own cycle, so the step is
  // applied to a zeroed view of the counters on that edge.
  assign w_presc_cur = w_entry ? '0   : r_presc;
  assign w_tv_cur    = w_entry ? '0   : timeValue;
  assign w_ovf_cur   = w_entry ? 1'b0 : overflow;
  assign w_wrap      = (w_presc_cur == PMAX);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_fsm                     <= IDLE;
      r_prev_state              <= 3'd0;
      r_presc                   <= '0;
      timeValue                 <= '0;
      start_timeValue_convetion <= 1'b0;
      running                   <= 1'b0;
      overflow                  <= 1'b0;
    end else begin
      r_prev_state              <= state;
      start_timeValue_convetion <= w_fin;
      if (w_count) begin
        r_fsm   <= COUNT;
        running <= 1'b1;
        if (w_wrap) begin
          r_presc <= '0;
          if (w_tv_cur == TMAX) begin
            timeValue <= TMAX;
            overflow  <= 1'b1;
          end else begin
            timeValue <= w_tv_cur + 1'b1;
            overflow  <= w_ovf_cur;
          end
        end else begin
          r_presc   <= w_presc_cur + 1'b1;
          timeValue <= w_tv_cur;
          overflow  <= w_ovf_cur;
        end
      end else if (r_fsm == COUNT) begin
        // Leaving execute: value freezes, partial prescale count is dropped.
        r_fsm   <= HELD;
        running <= 1'b0;
        r_presc <= '0;
      end
    end
  end

endmodule

// File: tb/tb_exec_timer.sv
// Directed bench for exec_timer: three instances (P=1/W=26, P=4/W=26, P=1/W=4)
// share one stimulus stream; expectations are queued, then popped and compared.
module tb_exec_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  state = 3'd0;

  logic [25:0] tv1, tv4;
  logic [3:0]  tvs;
  logic        p1, p4, ps, run1, run4, runs, ovf1, ovf4, ovfs;

  exec_timer #(.PRESCALE(1), .WIDTH(26)) u_p1 (
    .clk(clk), .rst(rst), .state(state), .timeValue(tv1),
    .start_timeValue_convetion(p1), .running(run1), .overflow(ovf1));
  exec_timer #(.PRESCALE(4), .WIDTH(26)) u_p4 (
    .clk(clk), .rst(rst), .state(state), .timeValue(tv4),
    .start_timeValue_convetion(p4), .running(run4), .overflow(ovf4));
  exec_timer #(.PRESCALE(1), .WIDTH(4)) u_sat (
    .clk(clk), .rst(rst), .state(state), .timeValue(tvs),
    .start_timeValue_convetion(ps), .running(runs), .overflow(ovfs));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int pcnt  = 0;
  int pbase = 0;

  // Count cycles in which the P=1 pulse is high.
  always @(negedge clk) if (p1 === 1'b1) pcnt <= pcnt + 1;

  typedef enum int {S_TV1, S_P1, S_RUN1, S_OVF1, S_TV4, S_OVF4, S_RUN4,
                    S_TVS, S_OVFS, S_PS, S_PCNT} sel_t;
  typedef struct {
    string       tag;
    sel_t        sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];

  function automatic logic [31:0] obs(sel_t s);
    case (s)
      S_TV1:  return 32'(tv1);
      S_P1:   return 32'(p1);
      S_RUN1: return 32'(run1);
      S_OVF1: return 32'(ovf1);
      S_TV4:  return 32'(tv4);
      S_OVF4: return 32'(ovf4);
      S_RUN4: return 32'(run4);
      S_TVS:  return 32'(tvs);
      S_OVFS: return 32'(ovfs);
      S_PS:   return 32'(ps);
      S_PCNT: return 32'(pcnt - pbase);
      default: return 32'hx;
    endcase
  endfunction

  task automatic expect_v(input string tag, input sel_t s, input logic [31:0] e);
    exp_t x;
    x.tag = tag; x.sel = s; x.exp = e;
    sb.push_back(x);
  endtask

  task automatic check();
    exp_t x;
    logic [31:0] o;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      o = obs(x.sel);
      tests++;
      assert (o === x.exp) else begin
        fails++;
        $error("FAIL %s: observed %0d expected %0d", x.tag, o, x.exp);
      end
    end
  endtask

  // Present st for n rising edges; returns 1 time unit after the last edge.
  task automatic drive(input logic [2:0] st, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      state = st;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // Reset held with state=4: everything stays zero.
    rst = 1'b0;
    drive(3'd4, 3);
    expect_v("rst_tv", S_TV1, 0);
    expect_v("rst_pulse", S_P1, 0);
    expect_v("rst_run", S_RUN1, 0);
    expect_v("rst_ovf", S_OVF1, 0);
    check();
    rst = 1'b1;
    drive(3'd4, 10);
    expect_v("rel_tv10", S_TV1, 10);
    expect_v("rel_run", S_RUN1, 1);
    check();
    drive(3'd3, 1);
    expect_v("rel_exit_tv", S_TV1, 10);
    expect_v("rel_exit_run", S_RUN1, 0);
    check();

    // Basic run: 100 execute edges then finish for 5 edges.
    pbase = pcnt;
    drive(3'd0, 1);
    drive(3'd4, 100);
    expect_v("basic_tv100", S_TV1, 100);
    expect_v("basic_p4_tv", S_TV4, 25);
    expect_v("basic_sat_tv", S_TVS, 15);
    expect_v("basic_sat_ovf", S_OVFS, 1);
    expect_v("basic_p4_ovf", S_OVF4, 0);
    check();
    drive(3'd6, 1);
    expect_v("basic_pulse_hi", S_P1, 1);
    expect_v("basic_pulse_tv", S_TV1, 100);
    expect_v("basic_run_lo", S_RUN1, 0);
    check();
    drive(3'd6, 1);
    expect_v("basic_pulse_lo", S_P1, 0);
    check();
    drive(3'd6, 3);
    expect_v("basic_pulse_cnt", S_PCNT, 1);
    expect_v("basic_hold_tv", S_TV1, 100);
    check();

    // Prescaler 4: runs of 10, 11, 12 give 2, 2, 3.
    drive(3'd0, 1);
    drive(3'd4, 10);
    drive(3'd3, 1);
    expect_v("pre_10", S_TV4, 2);
    expect_v("pre_10_ovf", S_OVF4, 0);
    expect_v("pre_10_run", S_RUN4, 0);
    check();
    drive(3'd4, 11);
    drive(3'd3, 1);
    expect_v("pre_11", S_TV4, 2);
    expect_v("pre_11_p1", S_TV1, 11);
    check();
    drive(3'd4, 12);
    drive(3'd3, 2);
    expect_v("pre_12", S_TV4, 3);
    expect_v("pre_12_ovf", S_OVF4, 0);
    expect_v("pre_12_sat", S_TVS, 12);
    check();

    // Saturation at WIDTH=4, then a short run clears overflow.
    drive(3'd0, 1);
    drive(3'd4, 15);
    expect_v("sat_15_noovf", S_OVFS, 0);
    expect_v("sat_15_tv", S_TVS, 15);
    check();
    drive(3'd4, 5);
    drive(3'd3, 1);
    expect_v("sat_tv", S_TVS, 15);
    expect_v("sat_ovf", S_OVFS, 1);
    expect_v("sat_wide_tv", S_TV1, 20);
    check();
    drive(3'd4, 5);
    drive(3'd3, 1);
    expect_v("sat_rerun_tv", S_TVS, 5);
    expect_v("sat_rerun_ovf", S_OVFS, 0);
    check();

    // Re-entry with repeated finish.
    pbase = pcnt;
    drive(3'd0, 1);
    drive(3'd4, 100);
    drive(3'd6, 1);
    expect_v("re_pulse1", S_P1, 1);
    expect_v("re_tv1", S_TV1, 100);
    check();
    drive(3'd0, 1);
    drive(3'd4, 5);
    drive(3'd6, 1);
    expect_v("re_pulse2", S_P1, 1);
    expect_v("re_tv2", S_TV1, 5);
    expect_v("re_sat_p", S_PS, 1);
    check();
    drive(3'd6, 2);
    expect_v("re_pulse_cnt", S_PCNT, 2);
    check();

    // Reset mid-count aborts, then a fresh 20-edge run.
    pbase = pcnt;
    drive(3'd0, 1);
    drive(3'd4, 50);
    rst = 1'b0;
    drive(3'd4, 1);
    expect_v("mid_rst_tv", S_TV1, 0);
    expect_v("mid_rst_run", S_RUN1, 0);
    check();
    rst = 1'b1;
    drive(3'd4, 20);
    expect_v("mid_tv20", S_TV1, 20);
    check();
    drive(3'd6, 1);
    expect_v("mid_pulse", S_P1, 1);
    expect_v("mid_pulse_tv", S_TV1, 20);
    check();
    drive(3'd6, 2);
    expect_v("mid_pulse_cnt", S_PCNT, 1);
    check();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
